// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-line instruction cache.
//
// Sits between the instruction fetcher and the memory controller's
// instruction port. A hit is answered combinationally in the same cycle. A
// miss sends one word request downstream, writes the returned word into the
// array and lets the fetcher hit on the following cycle.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rdy               global run enable; low freezes every register
//   clear             mispredict flush; abandons an outstanding miss
//   fetch_valid/pc    fetch request (pc[1:0] ignored)
//   inst_ready/out    combinational hit response
//   mem_valid/addr    registered word request to the memory controller
//   mem_enable/din    one-cycle fill pulse and its data word
//   dbg_state_o       current FSM state (0 = IDLE, 1 = WAIT)
//   hit_cnt/miss_cnt  statistics counters, only with ICACHE_STAT_EN
//
// Configuration macro: ICACHE_STAT_EN adds the hit/miss statistics counters.
//
// Handshake semantics:
//   Upstream: the fetcher consumes inst_out in any cycle where
//   fetch_valid && inst_ready && rdy; there is no back-pressure on the cache.
//   Downstream: mem_valid/mem_addr are raised together from a register and
//   held unchanged until the cycle in which mem_enable (or clear) is seen;
//   mem_valid is then low for at least one cycle before the next request.
// ----------------------------------------------------------------------------
module icache #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        inst_ready,
    output logic [31:0] inst_out,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_enable,
    input  logic [31:0] mem_din,
    output logic        dbg_state_o
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Storage. Only the valid bits are reset; tag/data need no reset because
    // a line is never read as a hit until its valid bit has been set.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // The outstanding miss address doubles as the fill address, so no
    // separate miss register is needed.
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             issue_miss;
    logic             do_fill;
    logic             unused_pc_bits;

    assign fetch_idx      = fetch_pc[IDX_W+1:2];
    assign fetch_tag      = fetch_pc[31:IDX_W+2];
    assign fill_idx       = mem_addr_q[IDX_W+1:2];
    assign fill_tag       = mem_addr_q[31:IDX_W+2];
    assign unused_pc_bits = ^fetch_pc[1:0];

    assign hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_valid && !hit && !clear) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // clear and mem_enable both end the wait; the fill itself is
                // handled by do_fill so a coincident clear still writes it.
                if (mem_enable || clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and strobes
    // ------------------------------------------------------------------
    always_comb begin
        inst_ready = 1'b0;
        issue_miss = 1'b0;
        do_fill    = 1'b0;
        case (state_q)
            S_IDLE: begin
                inst_ready = fetch_valid && hit && !rst && !clear;
                issue_miss = rdy && !rst && fetch_valid && !hit && !clear;
            end
            S_WAIT: begin
                do_fill = rdy && !rst && mem_enable;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Downstream request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else if (rdy) begin
            if (issue_miss) begin
                mem_valid_q <= 1'b1;
                mem_addr_q  <= {fetch_pc[31:2], 2'b00};
            end else if (state_q == S_WAIT && state_d == S_IDLE) begin
                // Dropping in the fill cycle guarantees the mandatory idle
                // cycle before any back-to-back request.
                mem_valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (do_fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_din;
        end
    end

    assign inst_out    = data_q[fetch_idx];
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign dbg_state_o = state_q;

`ifdef ICACHE_STAT_EN
    // ------------------------------------------------------------------
    // Statistics (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (inst_ready && rdy) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (issue_miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
